// File: rtl/imem_loader_if.sv
// Port bundle for imem_loader: load control, byte stream in, and the two bank
// write ports plus status out. The loader takes the slave view.
interface imem_loader_if #(
  parameter int BANK_AW = 10
);
  logic               start;
  logic [BANK_AW:0]   base_addr;
  logic [BANK_AW:0]   len;
  logic               abort;
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               ceb0, ceb1;
  logic               web0, web1;
  logic [BANK_AW-1:0] A0, A1;
  logic [15:0]        D0, D1;
  logic               busy;
  logic               done;
  logic [15:0]        checksum;

  modport slave (
    input  start, base_addr, len, abort, in_valid, in_data,
    output in_ready, ceb0, ceb1, web0, web1, A0, A1, D0, D1, busy, done, checksum
  );

  modport master (
    output start, base_addr, len, abort, in_valid, in_data,
    input  in_ready, ceb0, ceb1, web0, web1, A0, A1, D0, D1, busy, done, checksum
  );
endinterface

// File: rtl/imem_loader.sv
// Byte-stream programmer for the two-bank halfword instruction memory: packs
// little-endian byte pairs and writes halfword h to bank h[0] at index h>>1.
module imem_loader #(
  parameter int BANK_AW    = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LO   = 3'd1;
  localparam logic [2:0] S_HI   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [BANK_AW:0] ONE = {{BANK_AW{1'b0}}, 1'b1};

  logic [2:0]            state_q, state_d;
  logic [BANK_AW:0]      addr_q, addr_d;
  logic [BANK_AW:0]      remain_q, remain_d;
  logic [7:0]            lo_q, lo_d;
  logic [DATA_WIDTH-1:0] hw_q, hw_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    lo_d       = lo_q;
    hw_d       = hw_q;
    checksum_d = checksum_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          addr_d     = bus.base_addr;
          remain_d   = bus.len;
          checksum_d = '0;
          state_d    = (bus.len == '0) ? S_DONE : S_LO;
        end
      end
      S_LO: begin
        if (bus.abort) begin
          state_d = S_DONE;
        end else if (bus.in_valid) begin
          lo_d    = bus.in_data;
          state_d = S_HI;
        end
      end
      S_HI: begin
        // abort wins over a same-cycle byte; the partial halfword is dropped
        if (bus.abort) begin
          state_d = S_DONE;
        end else if (bus.in_valid) begin
          hw_d    = {bus.in_data, lo_q};
          state_d = S_WR;
        end
      end
      S_WR: begin
        checksum_d = checksum_q + hw_q;
        addr_d     = addr_q + ONE;
        remain_d   = remain_q - ONE;
        state_d    = (remain_q == ONE || bus.abort) ? S_DONE : S_LO;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      lo_q       <= '0;
      hw_q       <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      lo_q       <= lo_d;
      hw_q       <= hw_d;
      checksum_q <= checksum_d;
    end
  end

  logic wr0, wr1;

  // Bank ports are idle (and A/D parked at zero) outside the single WR cycle
  always_comb begin
    wr0          = (state_q == S_WR) && !addr_q[0];
    wr1          = (state_q == S_WR) &&  addr_q[0];
    bus.in_ready = (state_q == S_LO) || (state_q == S_HI);
    bus.ceb0     = !wr0;
    bus.web0     = !wr0;
    bus.ceb1     = !wr1;
    bus.web1     = !wr1;
    bus.A0       = wr0 ? addr_q[BANK_AW:1] : '0;
    bus.A1       = wr1 ? addr_q[BANK_AW:1] : '0;
    bus.D0       = wr0 ? hw_q : '0;
    bus.D1       = wr1 ? hw_q : '0;
    bus.busy     = (state_q != S_IDLE);
    bus.done     = (state_q == S_DONE);
    bus.checksum = checksum_q;
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; expected bank writes are queued as bytes are
// driven and checked against every WR cycle the loader produces.
module tb_imem_loader;
  localparam int AW = 10;

  typedef struct packed {
    logic          bank;
    logic [AW-1:0] a;
    logic [15:0]   d;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   wr_cnt    = 0;
  int   cyc       = 0;
  wr_t  exp_q[$];

  imem_loader_if #(.BANK_AW(AW)) bus ();

  imem_loader #(.BANK_AW(AW), .DATA_WIDTH(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Every bank access must match the next queued expectation
  always @(negedge clk) begin
    if (!reset && (bus.ceb0 === 1'b0 || bus.ceb1 === 1'b0)) begin
      wr_t e;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {bus.ceb0, bus.ceb1}, 32'h3);
      end else begin
        e = exp_q.pop_front();
        chk("wr_ceb", {bus.ceb0, bus.ceb1}, e.bank ? 32'h2 : 32'h1);
        chk("wr_web", {bus.web0, bus.web1}, e.bank ? 32'h2 : 32'h1);
        chk("wr_addr", e.bank ? bus.A1 : bus.A0, e.a);
        chk("wr_data", e.bank ? bus.D1 : bus.D0, e.d);
        chk("wr_in_ready", bus.in_ready, 1'b0);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic expect_wr(input logic [AW:0] h, input logic [15:0] d);
    wr_t e;
    e.bank = h[0];
    e.a    = h[AW:1];
    e.d    = d;
    exp_q.push_back(e);
  endtask

  task automatic start_load(input logic [AW:0] base, input logic [AW:0] n);
    bus.start = 1'b1; bus.base_addr = base; bus.len = n;
    step();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_valid = 1'b1; bus.in_data = b;
    while (bus.in_ready !== 1'b1 && n < 50) begin step(); n++; end
    if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_byte_gap(input logic [7:0] b);
    bus.in_valid = 1'b0;
    step();
    send_byte(b);
  endtask

  // Waits for the done pulse, then checks it lasts exactly one cycle
  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < 200) begin step(); n++; end
    chk({tag, "_done"}, bus.done, 1'b1);
    chk({tag, "_busy_in_done"}, bus.busy, 1'b1);
    step();
    chk({tag, "_done_pulse"}, {bus.done, bus.busy}, 32'h0);
  endtask

  initial begin
    int st, wr0;
    bus.start = 0; bus.base_addr = '0; bus.len = '0; bus.abort = 0;
    bus.in_valid = 0; bus.in_data = '0;
    reset = 1'b1;
    repeat (3) step();
    chk("rst_ctrl", {bus.in_ready, bus.ceb0, bus.ceb1, bus.web0, bus.web1, bus.busy, bus.done},
        7'b0111100);
    chk("rst_addr", {bus.A0, bus.A1}, 32'h0);
    chk("rst_data", {bus.D0, bus.D1}, 32'h0);
    chk("rst_sum", bus.checksum, 32'h0);
    reset = 1'b0;
    step();

    // 1: two halfwords from base 0
    start_load(11'h000, 11'd2);
    expect_wr(11'h000, 16'h0513); expect_wr(11'h001, 16'h0093);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h93); send_byte(8'h00);
    wait_done("t1");
    chk("t1_sum", bus.checksum, 16'h05A6);

    // 2: odd base starts in bank1
    start_load(11'h005, 11'd3);
    expect_wr(11'h005, 16'h0201); expect_wr(11'h006, 16'h0403); expect_wr(11'h007, 16'h0605);
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    wait_done("t2");
    chk("t2_sum", bus.checksum, 16'h0C09);

    // 3: address wraps from the top of bank1 to bank0 index 0
    start_load(11'h7FF, 11'd2);
    expect_wr(11'h7FF, 16'hBBAA); expect_wr(11'h000, 16'hDDCC);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    wait_done("t3");
    chk("t3_sum", bus.checksum, 16'h9976);

    // 4: zero length, then a start pulse while busy
    wr0 = wr_cnt;
    start_load(11'h123, 11'd0);
    chk("t4_len0_done", {bus.done, bus.busy}, 32'h3);
    wait_done("t4a");
    chk("t4_len0_nowr", wr_cnt - wr0, 0);
    chk("t4_len0_sum", bus.checksum, 16'h0);
    start_load(11'h010, 11'd1);
    expect_wr(11'h010, 16'h5678);
    start_load(11'h200, 11'd5);
    send_byte(8'h78); send_byte(8'h56);
    wait_done("t4b");
    chk("t4_sum", bus.checksum, 16'h5678);

    // 5: in_valid toggling, then abort mid-halfword
    st = cyc;
    start_load(11'h020, 11'd4);
    expect_wr(11'h020, 16'h1110); expect_wr(11'h021, 16'h1312);
    expect_wr(11'h022, 16'h1514); expect_wr(11'h023, 16'h1716);
    for (int i = 0; i < 8; i++) send_byte_gap(8'(8'h10 + i));
    wait_done("t5a");
    chk("t5_cycles", 32'(cyc - st >= 12), 1);
    chk("t5_sum", bus.checksum, 16'h504C);
    wr0 = wr_cnt;
    start_load(11'h030, 11'd3);
    expect_wr(11'h030, 16'h2221);
    send_byte(8'h21); send_byte(8'h22); send_byte(8'h23);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("t5_abort_done", bus.done, 1'b1);
    step();
    chk("t5_abort_busy", bus.busy, 1'b0);
    chk("t5_abort_wr", wr_cnt - wr0, 1);
    chk("t5_abort_sum", bus.checksum, 16'h2221);

    // 6: reset while holding the low byte of halfword 1
    start_load(11'h040, 11'd2);
    send_byte(8'h99);
    reset = 1'b1;
    step();
    chk("t6_rst_ceb", {bus.ceb0, bus.ceb1, bus.busy}, 32'h6);
    chk("t6_rst_sum", bus.checksum, 16'h0);
    reset = 1'b0;
    step();
    start_load(11'h001, 11'd1);
    expect_wr(11'h001, 16'h1234);
    send_byte(8'h34); send_byte(8'h12);
    wait_done("t6");
    chk("t6_sum", bus.checksum, 16'h1234);

    repeat (3) step();
    chk("queue_empty", exp_q.size(), 0);
    chk("total_writes", wr_cnt, 14);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
